multicycle_control: RTL

- Multicycle sequencer for the RV32I datapath (fetch, decode, register file, ALU, memory, writeback) around a single shared instruction/data memory port.
- Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB.
- Gates the write strobes that the decode stage produces combinationally, and arbitrates the memory port between instruction fetch and load/store.
- Provides a memory-ready handshake with timeout, halt and illegal-opcode detection, and a retired-instruction counter.

---
 rtl/rv_ctrl_pkg.sv | 34 +++
 rtl/mem_wait_timer.sv | 34 +++
 rtl/multicycle_control.sv | 130 +++++++++++++
 3 files changed

// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - state encodings and RV32I opcode constants for the multicycle sequencer
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_HALT    = 3'd6
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // SYSTEM is deliberately not "legal" here: it ends execution cleanly instead
  function automatic logic is_legal_op(input logic [6:0] opc);
    case (opc)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - wait-cycle counter shared by the fetch and data memory phases
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic incr_i,
  output logic expired_o
);

  localparam int unsigned CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TERM = CW'(MEM_TIMEOUT);

  logic [CW-1:0] count_q, count_d;

  // clear dominates; counting saturates at the terminal value
  always_comb begin
    count_d = count_q;
    if (clear_i)
      count_d = '0;
    else if (incr_i && (count_q != TERM))
      count_d = count_q + CW'(1);
  end

  // counter register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign expired_o = (count_q == TERM);

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle RV32I sequencer with shared memory port arbitration
module multicycle_control
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned COUNT_BITS  = 32,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [6:0]            opcode,
  input  logic                  dec_wEn,
  input  logic                  dec_mem_wEn,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_addr_sel,
  output logic                  mem_wEn,
  output logic                  ir_wEn,
  output logic                  pc_wEn,
  output logic                  rf_wEn,
  output logic                  halted,
  output logic                  illegal,
  output logic [2:0]            state,
  output logic                  timeout,
  output logic [COUNT_BITS-1:0] instret
);

  state_e                state_q, state_d;
  logic [COUNT_BITS-1:0] instret_q;
  logic                  halted_q, illegal_q, timeout_q;
  logic                  in_wait, wait_expired;
  logic                  is_mem_op, is_store, is_branch;
  logic                  illegal_op, mem_timeout;

  assign is_store   = (opcode == OPC_STORE);
  assign is_mem_op  = (opcode == OPC_LOAD) || is_store;
  assign is_branch  = (opcode == OPC_BRANCH);
  assign in_wait    = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign mem_timeout = in_wait && !mem_ready && wait_expired;
  assign illegal_op = (state_q == ST_DECODE) && !is_legal_op(opcode) && (opcode != OPC_SYSTEM);

  // Counter sits at zero outside the memory phases, so every entry to FETCH/MEM starts fresh
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (!in_wait || mem_ready),
    .incr_i    (in_wait && !mem_ready),
    .expired_o (wait_expired)
  );

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // next-state logic; mem_ready wins over a coincident timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready)         state_d = ST_DECODE;
        else if (wait_expired) state_d = ST_HALT;
      end
      ST_DECODE:  state_d = is_legal_op(opcode) ? ST_EXECUTE : ST_HALT;
      ST_EXECUTE: begin
        if (is_mem_op)      state_d = ST_MEM;
        else if (is_branch) state_d = ST_FETCH;
        else                state_d = ST_WB;
      end
      ST_MEM: begin
        if (mem_ready)         state_d = is_store ? ST_FETCH : ST_WB;
        else if (wait_expired) state_d = ST_HALT;
      end
      ST_WB:      state_d = ST_FETCH;
      ST_HALT:    state_d = ST_HALT;
      default:    state_d = ST_IDLE;
    endcase
  end

  // strobe outputs; pc_wEn doubles as the retire strobe
  always_comb begin
    mem_req      = 1'b0;
    mem_addr_sel = 1'b0;
    mem_wEn      = 1'b0;
    ir_wEn       = 1'b0;
    pc_wEn       = 1'b0;
    rf_wEn       = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        ir_wEn  = mem_ready;
      end
      ST_EXECUTE: pc_wEn = is_branch;
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_wEn      = dec_mem_wEn && mem_ready;
        pc_wEn       = is_store && mem_ready;
      end
      ST_WB: begin
        rf_wEn = dec_wEn;
        pc_wEn = 1'b1;
      end
      default: ;
    endcase
  end

  // retired-instruction counter (wraps silently) and sticky status flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instret_q <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (pc_wEn)               instret_q <= instret_q + COUNT_BITS'(1);
      if (state_d == ST_HALT)   halted_q  <= 1'b1;
      if (illegal_op)           illegal_q <= 1'b1;
      if (mem_timeout)          timeout_q <= 1'b1;
    end
  end

  assign state   = state_q;
  assign instret = instret_q;
  assign halted  = halted_q;
  assign illegal = illegal_q;
  assign timeout = timeout_q;

endmodule
